rom_fetch_sequencer: RTL and testbench

//  Sequences burst reads from one layer's weight ROM (1-cycle read latency, no read enable) and

---
 rtl/rom_seq_pkg.sv | 12 +
 rtl/rom_seq_skid_fifo.sv | 49 ++++
 rtl/rom_fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_rom_fetch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the ROM fetch sequencer.
package rom_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/rom_seq_skid_fifo.sv
// Two-entry FIFO that soaks up the ROM read latency under downstream backpressure.
module rom_seq_skid_fifo
    import rom_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count == 2'(BUF_DEPTH));
    assign empty_o    = (count == 2'd0);
    // A push into a full FIFO is legal only when a pop frees a slot in the same cycle.
    assign do_push    = push_i & (~full_o | pop_i);
    assign do_pop     = pop_i & ~empty_o;
    assign pop_data_o = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem    <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Burst reader for a 1-cycle-latency weight ROM, presented as a valid/ready stream.
// Optional macro ROM_LOAD_EN adds an IDLE-time write port for SRAM preload.
module rom_fetch_sequencer
    import rom_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WORD_SIZE  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_wen_o,
    input  logic [WORD_SIZE-1:0]  rom_data_i,
    output logic [WORD_SIZE-1:0]  data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i
`ifdef ROM_LOAD_EN
    ,
    input  logic                  load_valid_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [WORD_SIZE-1:0]  load_data_i,
    output logic                  load_ready_o,
    output logic [WORD_SIZE-1:0]  rom_wdata_o
`endif
);

    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_SIZE:0]    fifo_out;
    logic                  pop;
    logic                  can_issue;
    logic                  issue;
    logic                  last_issue;

    assign pop        = ~fifo_empty & ready_i;
    assign last_issue = (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});

    // Issue only if buffer occupancy after this edge (count + inflight - pop)
    // leaves room for the word that lands two edges later; counting the pop
    // keeps 1 word/cycle sustained with ready held high.
    assign can_issue = fifo_empty
                     | (~fifo_full & (~inflight_q | pop))
                     | (fifo_full & pop & ~inflight_q);
    assign issue     = (state == FETCH) & can_issue;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue & last_issue;
            case (state)
                IDLE: begin
`ifdef ROM_LOAD_EN
                    if (load_valid_i) begin
                        addr_q <= load_addr_i;
                    end else
`endif
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q      <= base_addr_i;
                            remaining_q <= len_i;
                            state       <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (last_issue) begin
                            state <= DRAIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_out[WORD_SIZE]) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rom_seq_skid_fifo #(
        .WIDTH(WORD_SIZE + 1)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .push_i     (inflight_q),
        .push_data_i({inflight_last_q, rom_data_i}),
        .pop_i      (pop),
        .pop_data_o (fifo_out),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign busy_o     = (state != IDLE);
    assign done_o     = done_q;
    assign rom_addr_o = addr_q;
    assign valid_o    = ~fifo_empty;
    assign data_o     = fifo_out[WORD_SIZE-1:0];
    assign last_o     = ~fifo_empty & fifo_out[WORD_SIZE];

`ifdef ROM_LOAD_EN
    logic                 rom_wen_q;
    logic [WORD_SIZE-1:0] rom_wdata_q;
    logic                 load_take;

    assign load_take = (state == IDLE) & load_valid_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rom_wen_q   <= 1'b1;
            rom_wdata_q <= '0;
        end else begin
            rom_wen_q <= ~load_take;
            if (load_take) begin
                rom_wdata_q <= load_data_i;
            end
        end
    end

    assign rom_wen_o    = rom_wen_q;
    assign rom_wdata_o  = rom_wdata_q;
    assign load_ready_o = (state == IDLE);
`else
    assign rom_wen_o = 1'b1;
`endif

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Randomised self-checking bench for rom_fetch_sequencer against a queue-based burst model.
module tb_rom_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [7:0]  base_addr_i;
    logic [8:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  rom_addr_o;
    logic        rom_wen_o;
    logic [15:0] rom_data;
    logic [15:0] data_o;
    logic        valid_o;
    logic        last_o;
    logic        ready_i;
`ifdef ROM_LOAD_EN
    logic        load_valid_i;
    logic [7:0]  load_addr_i;
    logic [15:0] load_data_i;
    logic        load_ready_o;
    logic [15:0] rom_wdata_o;
`endif

    logic [15:0] rom_mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_fetch_sequencer #(
        .ADDR_WIDTH(8),
        .WORD_SIZE (16)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rom_addr_o  (rom_addr_o),
        .rom_wen_o   (rom_wen_o),
        .rom_data_i  (rom_data),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i)
`ifdef ROM_LOAD_EN
        ,
        .load_valid_i(load_valid_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i),
        .load_ready_o(load_ready_o),
        .rom_wdata_o (rom_wdata_o)
`endif
    );

    // Synchronous ROM/SRAM model: data appears one cycle after the address.
    always @(posedge clk) begin
`ifdef ROM_LOAD_EN
        if (!rom_wen_o) rom_mem[rom_addr_o] <= rom_wdata_o;
`endif
        rom_data <= rom_mem[rom_addr_o];
    end

    // Drives one burst and checks every word against the expected ROM sequence.
    // mode: 0 ready high, 1 ready toggling, 2 ready random.
    task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode,
                             input bit pre_started, input bit poke_mid, input bit chain,
                             input logic [7:0] nbase, input logic [8:0] nlen);
        logic [16:0] exp_q[$];
        logic [16:0] exp_w;
        int          first_valid = -1;
        int          last_xfer = -1;
        int          done_k = -1;
        int          limit;
        logic        stall_prev = 1'b0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [7:0]  addr_before;
        for (int unsigned i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), rom_mem[8'(base + i)]});
        addr_before = rom_addr_o;
        if (!pre_started) begin
            @(negedge clk);
            addr_before = rom_addr_o;
            start_i = 1'b1; base_addr_i = base; len_i = len;
        end
        limit = 4 * int'(len) + 20;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (k == 0) start_i = 1'b0;
            if (poke_mid && k == 3) begin
                start_i = 1'b1; base_addr_i = base + 8'h40; len_i = 9'd3;
            end else if (poke_mid && k == 4) begin
                start_i = 1'b0;
            end
            if (done_o) begin
                done_k = k;
                break;
            end
            total++;
            if (busy_o !== (len != 0))
                begin bad++; $display("FAIL busy_during k=%0d: got %b want %b", k, busy_o, (len != 0)); end
            if (len == 0) begin
                total++;
                if (rom_addr_o !== addr_before || valid_o !== 1'b0)
                    begin bad++; $display("FAIL zero_len_quiet: addr %h valid %b want addr %h valid 0", rom_addr_o, valid_o, addr_before); end
            end
            if (stall_prev) begin
                total++;
                if (valid_o !== 1'b1 || data_o !== prev_data || last_o !== prev_last)
                    begin bad++; $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", valid_o, data_o, last_o, prev_data, prev_last); end
            end
            case (mode)
                0: ready_i = 1'b1;
                1: ready_i = (k % 2 == 0);
                default: ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (valid_o) begin
                if (first_valid < 0) first_valid = k;
                if (ready_i) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL extra_word: got %h want none", data_o);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if ({last_o, data_o} !== exp_w)
                            begin bad++; $display("FAIL word base=%h: got last=%b data=%h want last=%b data=%h", base, last_o, data_o, exp_w[16], exp_w[15:0]); end
                    end
                    last_xfer = k;
                end
            end
            stall_prev = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
        end
        total++;
        if (done_k < 0) begin bad++; $display("FAIL done_timeout base=%h len=%0d: got none want pulse", base, len); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL words_missing: got %0d left want 0", exp_q.size()); end
        if (done_k >= 0) begin
            total++;
            if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_at_done: got %b want 0", busy_o); end
            total++;
            if (done_k != ((len == 0) ? 0 : last_xfer + 1))
                begin bad++; $display("FAIL done_timing: got k=%0d want k=%0d", done_k, (len == 0) ? 0 : last_xfer + 1); end
        end
        if (mode == 0 && len != 0) begin
            total++;
            if (first_valid != 2) begin bad++; $display("FAIL first_valid_latency: got %0d want 2", first_valid); end
            total++;
            if (last_xfer != first_valid + int'(len) - 1)
                begin bad++; $display("FAIL sustained_rate: got last at %0d want %0d", last_xfer, first_valid + int'(len) - 1); end
        end
        if (chain) begin
            start_i = 1'b1; base_addr_i = nbase; len_i = nlen;
        end else begin
            @(negedge clk);
            total++;
            if (done_o !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done_o); end
        end
    endtask

    task automatic test_reset();
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || valid_o !== 1'b0 || last_o !== 1'b0)
            begin bad++; $display("FAIL reset_flags: got b=%b d=%b v=%b l=%b want 0000", busy_o, done_o, valid_o, last_o); end
        total++;
        if (rom_addr_o !== 8'h00 || rom_wen_o !== 1'b1)
            begin bad++; $display("FAIL reset_rom: got addr=%h wen=%b want addr=00 wen=1", rom_addr_o, rom_wen_o); end
`ifdef ROM_LOAD_EN
        total++;
        if (load_ready_o !== 1'b1 || rom_wdata_o !== 16'h0)
            begin bad++; $display("FAIL reset_load: got ready=%b wdata=%h want 1 0000", load_ready_o, rom_wdata_o); end
`endif
    endtask

    task automatic test_basic();
        run_burst(8'h10, 9'd4, 0, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask

    task automatic test_backpressure();
        run_burst(8'h40, 9'd6, 1, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask

    task automatic test_wrap();
        run_burst(8'hFE, 9'd4, 0, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask

    task automatic test_zero_len();
        run_burst(8'h77, 9'd0, 0, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask

    task automatic test_back_to_back();
        run_burst(8'h20, 9'd6, 0, 1'b0, 1'b1, 1'b1, 8'h90, 9'd5);
        run_burst(8'h90, 9'd5, 0, 1'b1, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_burst(8'($urandom), 9'($urandom_range(1, 24)), 2, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
        run_burst(8'($urandom), 9'd256, 0, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 8'h30; len_i = 9'd8; ready_i = 1'b1;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o) seen++;
        end
        total++;
        if (seen != 2) begin bad++; $display("FAIL reset_mid_setup: got %0d transfers want 2", seen); end
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || valid_o !== 1'b0 || last_o !== 1'b0)
            begin bad++; $display("FAIL reset_mid_flags: got b=%b d=%b v=%b l=%b want 0000", busy_o, done_o, valid_o, last_o); end
        total++;
        if (rom_addr_o !== 8'h00 || rom_wen_o !== 1'b1)
            begin bad++; $display("FAIL reset_mid_rom: got addr=%h wen=%b want 00 1", rom_addr_o, rom_wen_o); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (done_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0)
                begin bad++; $display("FAIL reset_mid_after k=%0d: got d=%b v=%b b=%b want 000", k, done_o, valid_o, busy_o); end
        end
    endtask

`ifdef ROM_LOAD_EN
    task automatic test_load();
        @(negedge clk);
        load_valid_i = 1'b1; load_addr_i = 8'h05; load_data_i = 16'hBEEF;
        total++;
        if (load_ready_o !== 1'b1) begin bad++; $display("FAIL load_ready_idle: got %b want 1", load_ready_o); end
        @(negedge clk);
        load_valid_i = 1'b0;
        total++;
        if (rom_wen_o !== 1'b0 || rom_addr_o !== 8'h05 || rom_wdata_o !== 16'hBEEF)
            begin bad++; $display("FAIL load_write: got wen=%b addr=%h wdata=%h want 0 05 beef", rom_wen_o, rom_addr_o, rom_wdata_o); end
        @(negedge clk);
        total++;
        if (rom_wen_o !== 1'b1) begin bad++; $display("FAIL load_one_cycle: got wen=%b want 1", rom_wen_o); end
        total++;
        if (rom_mem[5] !== 16'hBEEF) begin bad++; $display("FAIL load_stored: got %h want beef", rom_mem[5]); end
        run_burst(8'h05, 9'd1, 0, 1'b0, 1'b0, 1'b0, 8'h0, 9'd0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = {8'(i), 8'($urandom)};
        reset_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; ready_i = 1'b1;
`ifdef ROM_LOAD_EN
        load_valid_i = 1'b0; load_addr_i = '0; load_data_i = '0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef ROM_LOAD_EN
        test_load();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
